// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types for the core's data-memory interface.
//   MemAccessType : request/response kind (WRITE=0, READ=1)
//   WORD_BYTES    : bytes per data-memory word
//   MemRspState   : responder FSM states (exported so benches can name them)
//   merge_bytes   : byte-enable merge of new data over an old word
package mips_core_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } MemAccessType;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_WAIT = 2'd1,
        MRS_RESP = 2'd2
    } MemRspState;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [WORD_BYTES-1:0] be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x 32-bit word store, one shared address port.
//   clk    in   clock
//   addr   in   word index
//   we     in   write strobe; only the bytes selected by be are written
//   be     in   byte enables, bit i covers wdata[8i+7:8i]
//   wdata  in   write data
//   re     in   read strobe; rdata loads mem[addr] on the same edge
//   rdata  out  registered read data, held until the next read
// The store is deliberately not reset. Reads and writes are never issued in
// the same cycle by the responder, so same-index collision ordering is moot.
import mips_core_pkg::*;

module data_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    // Per-byte write enables so synthesis can map onto byte-write RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the core's data-memory request channel.
// Accepts one READ/WRITE at a time, performs the access at the handshake edge,
// then presents the response LATENCY cycles later and holds it until taken.
//   clk, rst   clock; asynchronous active-high reset
//   req_*      request channel (valid/ready, type, byte address, wdata, byte enables)
//   rsp_*      response channel (valid/ready, echoed type, read data, error)
// Parameters: DEPTH words (power of two, >= 2), LATENCY 1..15.
import mips_core_pkg::*;

module data_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_type,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_type,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    MemRspState   state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    MemAccessType type_q;
    logic         err_q;
    logic         fire;
    logic         addr_err;
    logic         is_read;
    logic [31:0]  arr_rdata;

    // Ready drops combinationally with rst so nothing is accepted during reset.
    assign req_ready = (state == MRS_IDLE) && !rst;
    assign fire      = req_valid && req_ready;
    assign is_read   = (req_type == READ);

    // Range check on the full word address so high address bits never alias.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .addr  (req_addr[2 +: AW]),
        .we    (fire && !is_read && !addr_err),
        .be    (req_be),
        .wdata (req_wdata),
        .re    (fire && is_read && !addr_err),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MRS_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MRS_IDLE: begin
                if (fire) begin
                    if (LATENCY == 1) begin
                        state_nxt = MRS_RESP;
                    end else begin
                        state_nxt = MRS_WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            MRS_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = MRS_RESP;
            end
            MRS_RESP: begin
                // No new request is taken here, even on the response handshake.
                if (rsp_ready) state_nxt = MRS_IDLE;
            end
            default: begin
                state_nxt = MRS_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Request attributes captured only at the handshake, so idle-bus garbage
    // on the request inputs never reaches state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q <= WRITE;
            err_q  <= 1'b0;
        end else if (fire) begin
            type_q <= MemAccessType'(req_type);
            err_q  <= addr_err;
        end
    end

    // The array's read register holds the word loaded at the handshake edge
    // until the next accepted read, so the response data is simply gated by state.
    assign rsp_valid = (state == MRS_RESP);
    assign rsp_type  = type_q;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && (type_q == READ) && !err_q) ? arr_rdata : 32'h0;

endmodule
